// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types and default timing for the VGA raster sequencer.
// Default geometry is 640x480 at the standard porch/sync widths.
package vga_timing_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PIX_W = 10;
  localparam int RGB_W = 3 * PIX_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [RGB_W-1:0] DEF_UFLOW_RGB = 30'h3FF00000;

  // Width needed to hold 0..total-1, never below one bit.
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_line_counter.sv
// One raster axis: counts 0..TOTAL-1 and decodes active and sync.
// Used once for pixels within a line and once for lines within a frame.
module vga_line_counter
  import vga_timing_ctrl_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = cnt_w(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_active,
  output logic         sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // BP >= 1 keeps the sync end below TOTAL, so all fit in W bits.
  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT   = W'(ACTIVE);
  localparam logic [W-1:0] S_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] S_END = W'(ACTIVE + FP + SYNC);

  logic at_last;
  logic in_sync;

  assign at_last   = (cnt == LAST);
  assign wrap      = inc & at_last;
  assign in_active = (cnt < ACT);
  assign in_sync   = (cnt >= S_BEG) && (cnt < S_END);
  assign sync      = in_sync ? POL : ~POL;

  // Position counter: cleared while idle, wraps at the end of the axis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster sequencer: FSM, pixel handshake, underflow flag and
// registered video outputs driven from the h/v line counters.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int               H_ACTIVE  = DEF_H_ACTIVE,
  parameter int               H_FP      = DEF_H_FP,
  parameter int               H_SYNC    = DEF_H_SYNC,
  parameter int               H_BP      = DEF_H_BP,
  parameter int               V_ACTIVE  = DEF_V_ACTIVE,
  parameter int               V_FP      = DEF_V_FP,
  parameter int               V_SYNC    = DEF_V_SYNC,
  parameter int               V_BP      = DEF_V_BP,
  parameter bit               HSYNC_POL = 1'b0,
  parameter bit               VSYNC_POL = 1'b0,
  parameter logic [RGB_W-1:0] UFLOW_RGB = DEF_UFLOW_RGB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pix_valid,
  input  logic [RGB_W-1:0] pix_data,
  output logic             pix_ready,
  input  logic             clr_uflow,
  output logic             hsync,
  output logic             vsync,
  output logic [PIX_W-1:0] red,
  output logic [PIX_W-1:0] green,
  output logic [PIX_W-1:0] blue,
  output logic             de,
  output logic             sof,
  output logic             uflow,
  output logic             busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);

  state_t          state;
  logic            run;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic            h_wrap;
  logic            v_wrap;
  logic            h_act;
  logic            v_act;
  logic            h_sync;
  logic            v_sync;
  logic            active;
  logic            origin;
  logic [RGB_W-1:0] rgb_next;

  assign run = (state != IDLE);

  vga_line_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .W      (HW)
  ) u_hcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (~run),
    .inc       (run),
    .cnt       (hcnt),
    .wrap      (h_wrap),
    .in_active (h_act),
    .sync      (h_sync)
  );

  vga_line_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .W      (VW)
  ) u_vcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (~run),
    .inc       (h_wrap),
    .cnt       (vcnt),
    .wrap      (v_wrap),
    .in_active (v_act),
    .sync      (v_sync)
  );

  assign active    = h_act & v_act & run;
  assign pix_ready = active;
  assign busy      = run;
  assign origin    = (hcnt == '0) && (vcnt == '0);

  // Pixel selection for the next output register load.
  always_comb begin
    rgb_next = '0;
    if (active) begin
      rgb_next = pix_valid ? pix_data : UFLOW_RGB;
    end
  end

  // Run control: DRAIN finishes the frame unless enable returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (enable) state <= RUN;
          else if (v_wrap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Video outputs, one cycle behind the counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      red   <= '0;
      green <= '0;
      blue  <= '0;
      de    <= 1'b0;
      sof   <= 1'b0;
    end else begin
      hsync <= h_sync;
      vsync <= v_sync;
      red   <= rgb_next[3*PIX_W-1:2*PIX_W];
      green <= rgb_next[2*PIX_W-1:PIX_W];
      blue  <= rgb_next[PIX_W-1:0];
      de    <= active;
      sof   <= run & origin;
    end
  end

  // Sticky underflow; a new underflow beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow <= 1'b0;
    end else if (active && !pix_valid) begin
      uflow <= 1'b1;
    end else if (clr_uflow) begin
      uflow <= 1'b0;
    end
  end

endmodule
